// File: rtl/regfile_read_sequencer.sv
// Serializes the two operand reads of a decode request onto a single-read-port
// register file, with a combinational writeback pass-through and operand snooping.
module regfile_read_sequencer #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_dout
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, CAP, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_rs1;
  logic [ADDR_WIDTH-1:0] r_rs2;
  logic [DATA_WIDTH-1:0] r_rs1_data;
  logic [DATA_WIDTH-1:0] r_rs2_data;
  logic                  w_snoop1;
  logic                  w_snoop2;

  // Writeback is never stalled; x0 writes are dropped here.
  assign rf_we         = wb_we & (wb_addr != '0);
  assign rf_write_addr = wb_addr;
  assign rf_din        = wb_data;

  assign rs1_data = r_rs1_data;
  assign rs2_data = r_rs2_data;

  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rf_read_addr = r_rs1;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = RD1;
      end
      RD1:  w_next = RD2;
      RD2: begin
        rf_read_addr = r_rs2;
        w_next       = CAP;
      end
      CAP:  w_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Writes landing after the regfile already sampled an operand must be snooped;
  // rf_we already excludes x0, so a zero index can never match.
  always_comb begin
    w_snoop1 = rf_we && (wb_addr == r_rs1) &&
               ((r_state == RD2) || (r_state == CAP) || (r_state == RESP));
    w_snoop2 = rf_we && (wb_addr == r_rs2) &&
               ((r_state == CAP) || (r_state == RESP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1 <= '0;
      r_rs2 <= '0;
    end else if ((r_state == IDLE) && req_valid) begin
      r_rs1 <= rs1_addr;
      r_rs2 <= rs2_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
    end else begin
      if (w_snoop1)
        r_rs1_data <= wb_data;
      else if (r_state == RD2)
        r_rs1_data <= (r_rs1 == '0) ? '0 : rf_dout;

      if (w_snoop2)
        r_rs2_data <= wb_data;
      else if (r_state == CAP)
        r_rs2_data <= (r_rs2 == '0) ? '0 : rf_dout;
    end
  end

endmodule

// File: tb/tb_regfile_read_sequencer.sv
// Bench for regfile_read_sequencer: behavioural regfile, directed requests,
// and a queue-based scoreboard checked on each response handshake.
module tb_regfile_read_sequencer;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rf_we;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_din;
  logic [AW-1:0] rf_read_addr;
  logic [DW-1:0] rf_dout;

  regfile_read_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_we(rf_we), .rf_write_addr(rf_write_addr), .rf_din(rf_din),
    .rf_read_addr(rf_read_addr), .rf_dout(rf_dout)
  );

  always #5 clk = ~clk;

  // Registered-read regfile with write forwarding; x0 returns garbage so the
  // sequencer's own zero forcing is what gets observed.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (rf_we) mem[rf_write_addr] <= rf_din;
    if (rf_read_addr == '0)                          rf_dout <= 32'hDEAD_BEEF;
    else if (rf_we && rf_write_addr == rf_read_addr) rf_dout <= rf_din;
    else                                             rf_dout <= mem[rf_read_addr];
  end

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned cyc     = 0;
  int unsigned acc_cyc = 0;
  bit          pend_lat = 1'b0;
  logic [63:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // Monitor: latency from request cycle, and scoreboard pop on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_lat = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        acc_cyc  = cyc;
        pend_lat = 1'b1;
      end
      if (rsp_valid && pend_lat) begin
        chk("latency", cyc - acc_cyc, 32'd4);
        pend_lat = 1'b0;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("rsp_rs1_data", rs1_data, e[63:32]);
          chk("rsp_rs2_data", rs2_data, e[31:0]);
        end
      end
    end
  end

  task automatic send(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input bit push, input logic [31:0] e1, input logic [31:0] e2);
    @(posedge clk); #1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    rs1_addr  = a1;
    rs2_addr  = a2;
    if (push) exp_q.push_back({e1, e2});
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 20);
    chk("idle_within_bound", 32'(req_ready), 32'd1);
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    logic [AW-1:0] pa [4];
    logic [DW-1:0] pd [4];
    pa = '{5'd3, 5'd7, 5'd5, 5'd4};
    pd = '{32'h11, 32'h22, 32'hABCD, 32'h1};
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    rs1_addr = '0; rs2_addr = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rs1_data", rs1_data, 32'd0);
    chk("rst_rs2_data", rs2_data, 32'd0);
    chk("rst_rf_read_addr", 32'(rf_read_addr), 32'd0);

    // Preload through the writeback port while reset is held.
    for (int i = 0; i < 4; i++) begin
      wb(pa[i], pd[i]);
      #1;
      chk("rst_rf_we", 32'(rf_we), 32'd1);
      chk("rst_rf_write_addr", 32'(rf_write_addr), 32'(pa[i]));
      chk("rst_rf_din", rf_din, pd[i]);
      @(posedge clk); #1;
    end
    wb_we = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Basic read x3/x7
    send(5'd3, 5'd7, 1'b1, 32'h11, 32'h22);
    chk("rd1_read_addr", 32'(rf_read_addr), 32'd3);
    @(posedge clk); #1;
    chk("rd2_read_addr", 32'(rf_read_addr), 32'd7);
    wait_idle();

    // rs1 = x0, with a dropped x0 write in RD1
    send(5'd0, 5'd5, 1'b1, 32'h0, 32'hABCD);
    wb(5'd0, 32'hFFFF);
    #1;
    chk("x0_rf_we", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    wb_we = 1'b0;
    wait_idle();

    // Same register twice: forwarded write in RD1, snooped write in CAP
    send(5'd4, 5'd4, 1'b1, 32'h55, 32'h55);
    wb(5'd4, 32'h99);
    @(posedge clk); #1;
    wb_we = 1'b0;
    @(posedge clk); #1;
    chk("same_reg_rs1_fwd", rs1_data, 32'h99);
    wb(5'd4, 32'h55);
    @(posedge clk); #1;
    wb_we = 1'b0;
    wait_idle();

    // Write to rs1 during RD2 overrides the stale capture
    send(5'd5, 5'd3, 1'b1, 32'h5555, 32'h11);
    @(posedge clk); #1;
    wb(5'd5, 32'h5555);
    @(posedge clk); #1;
    wb_we = 1'b0;
    wait_idle();

    // Backpressure in RESP with a snooped rs2 write
    rsp_ready = 1'b0;
    send(5'd3, 5'd7, 1'b1, 32'h11, 32'h77);
    repeat (3) @(posedge clk);
    #1;
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_rs1", rs1_data, 32'h11);
    chk("resp_rs2_before", rs2_data, 32'h22);
    wb(5'd7, 32'h77);
    @(posedge clk); #1;
    wb_we = 1'b0;
    chk("hold_rs2_snooped", rs2_data, 32'h77);
    chk("hold_rs1", rs1_data, 32'h11);
    chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("hold_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("hold2_rs2", rs2_data, 32'h77);
    chk("hold2_req_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_hs_idle", 32'(req_ready), 32'd1);

    // Reset in CAP abandons the request
    send(5'd3, 5'd7, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("cap_rs1_loaded", rs1_data, 32'h11);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rs1", rs1_data, 32'd0);
    chk("midrst_rs2", rs2_data, 32'd0);
    chk("midrst_read_addr", 32'(rf_read_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", 32'(req_ready), 32'd1);
    send(5'd3, 5'd0, 1'b1, 32'h11, 32'h0);
    wait_idle();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
